// File: rtl/quantum_rr_arb.sv
// Round-robin arbiter granting each holder a slice of `quantum` advance-qualified cycles.
// Optional feature: define QUANTUM_ARB_LOCK_EN to add the `lock` input that holds off expiry.
module quantum_rr_arb #(
    parameter int ports   = 4,
    parameter int quantum = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [ports-1:0] request,
    input  logic             advance,
`ifdef QUANTUM_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [ports-1:0] grant,
    output logic             expire
);

    localparam int PW = (ports > 1) ? $clog2(ports) : 1;
    localparam int CW = (quantum > 1) ? $clog2(quantum) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(quantum - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] LAST_IDX = PW'(ports - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   PORTS_W  = (PW + 1)'(ports);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      h_r;
    logic [PW-1:0]      ptr_r;
    logic [CW-1:0]      cnt_r;
    logic [ports-1:0]   grant_r;
    logic               expire_r;

    logic [ports-1:0]   cand_s;
    logic               found_s;
    logic [PW-1:0]      pick_s;
    logic [PW:0]        idx_s;
    logic [PW-1:0]      next_ptr_s;
    logic               lock_s;

    function automatic logic [ports-1:0] to_onehot(input logic [PW-1:0] idx);
        logic [ports-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

`ifdef QUANTUM_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // Candidate set: while busy the holder is excluded so expiry only sees other requesters.
    always_comb begin
        if (state_r == BUSY) begin
            cand_s = request & ~to_onehot(h_r);
        end else begin
            cand_s = request;
        end
    end

    // First candidate at or after ptr, wrapping modulo ports.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int k = 0; k < ports; k++) begin
            idx_s = {1'b0, ptr_r} + (PW + 1)'(k);
            if (idx_s >= PORTS_W) begin
                idx_s = idx_s - PORTS_W;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && cand_s[idx_s[PW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer value that follows a grant to pick_s.
    always_comb begin
        if (pick_s == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = pick_s + PTR_ONE;
        end
    end

    // Arbitration FSM; release outranks expiry, and a locked holder saturates its counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            h_r      <= '0;
            ptr_r    <= '0;
            cnt_r    <= '0;
            grant_r  <= '0;
            expire_r <= 1'b0;
        end else begin
            expire_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= BUSY;
                        h_r     <= pick_s;
                        ptr_r   <= next_ptr_s;
                        cnt_r   <= '0;
                        grant_r <= to_onehot(pick_s);
                    end
                end
                BUSY: begin
                    if (!request[h_r]) begin
                        cnt_r <= '0;
                        if (found_s) begin
                            h_r     <= pick_s;
                            ptr_r   <= next_ptr_s;
                            grant_r <= to_onehot(pick_s);
                        end else begin
                            state_r <= IDLE;
                            grant_r <= '0;
                        end
                    end else if (advance && (cnt_r == CNT_LAST)) begin
                        if (lock_s) begin
                            cnt_r <= CNT_LAST;
                        end else if (found_s) begin
                            h_r      <= pick_s;
                            ptr_r    <= next_ptr_s;
                            cnt_r    <= '0;
                            grant_r  <= to_onehot(pick_s);
                            expire_r <= 1'b1;
                        end else begin
                            cnt_r <= '0;
                        end
                    end else if (advance) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign grant  = grant_r;
    assign expire = expire_r;

endmodule

// File: tb/tb_quantum_rr_arb.sv
// Scoreboard bench for quantum_rr_arb with ports=4, quantum=3; lock checks need QUANTUM_ARB_LOCK_EN.
module tb_quantum_rr_arb;

    logic       clock;
    logic       reset_n;
    logic [3:0] request;
    logic       advance;
    logic       lock_in;
    logic [3:0] grant;
    logic       expire;

    int errors;
    int checks;

    logic [4:0] exp_q[$];
    string      name_q[$];

    quantum_rr_arb #(.ports(4), .quantum(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .request (request),
        .advance (advance),
`ifdef QUANTUM_ARB_LOCK_EN
        .lock    (lock_in),
`endif
        .grant   (grant),
        .expire  (expire)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got grant=%b expire=%b, expected grant=%b expire=%b",
                     name, got[4:1], got[0], want[4:1], want[0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the response expected after the next rising edge.
    task automatic step(input string name, input logic rst, input logic [3:0] req, input logic adv,
                        input logic lck, input logic [3:0] eg, input logic ee);
        @(negedge clock);
        reset_n = rst;
        request = req;
        advance = adv;
        lock_in = lck;
        exp_q.push_back({eg, ee});
        name_q.push_back(name);
    endtask

    // Monitor: one sample per rising edge, compared against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), {grant, expire}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        request = 4'b0000;
        advance = 1'b0;
        lock_in = 1'b0;

        // Reset holds grant low; first edge after release grants.
        step("in_reset0", 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0);
        step("in_reset1", 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0);
        step("first_grant", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("slice_cnt1", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("slice_cnt2", 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0);

        // Mid-slice reset must clear outputs without waiting for a clock edge.
        @(negedge clock);
        reset_n = 1'b0;
        request = 4'b1111;
        #1;
        check("async_reset", {grant, expire}, 5'b00000);
        exp_q.push_back(5'b00000);
        name_q.push_back("held_reset");

        // Full rotation: ptr restarts at 0, so 1111 grants index 0 first.
        step("rot_0a", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("rot_0b", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("rot_0c", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("rot_1a", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
        step("rot_1b", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0);
        step("rot_1c", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0);
        step("rot_2a", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
        step("rot_2b", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0);
        step("rot_2c", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0);
        step("rot_3a", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
        step("rot_3b", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0);
        step("rot_3c", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0);
        step("rot_wrap", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        step("rot_w1", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("rot_w2", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("rot_to1", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);

        // Holder 0010 releases while 1101 is pending: direct handoff to 0100.
        step("release_handoff", 1'b1, 4'b1101, 1'b1, 1'b0, 4'b0100, 1'b0);

        // Sole requester renews its slice silently.
        for (int i = 0; i < 12; i++) begin
            step("sole_requester", 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0);
        end

        // Go idle, then regrant index 0 and stall the counter.
        step("to_idle", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        step("regrant0", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("stalled", 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0);
        end
        step("adv_cnt1", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        step("adv_cnt2", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
        // Release on the expiry edge wins: no expire pulse.
        step("release_on_expiry", 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0010, 1'b0);

`ifdef QUANTUM_ARB_LOCK_EN
        step("lk_idle", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        step("lk_grant0", 1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("locked_hold", 1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b0);
        end
        step("unlock_expire", 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1);
`endif

        step("tail", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
